instruction_queue: RTL

Circular FIFO that buffers fetched instructions between the instruction fetch unit and decode/issue. Accepts one {pc, instruction} entry per cycle through a valid/ready handshake from the fetcher, and presents the oldest entry to the decoder through a second valid/ready handshake. A synchronous flush discards all buffered entries on branch redirect.

---
 rtl/instruction_queue_if.sv | 23 ++
 rtl/instruction_queue.sv | 76 +++++++
 2 files changed

// File: rtl/instruction_queue_if.sv
// Fetch-side and issue-side valid/ready handshakes of the instruction queue.
// master = fetcher/decoder environment, slave = the queue itself.
interface instruction_queue_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int INST_WIDTH = 32
);
  logic                             inst_queue_entry_valid;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] inst_queue_entry;
  logic                             inst_queue_ready;
  logic                             issue_ready;
  logic                             issue_valid;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] issue_entry;

  modport master (
    output inst_queue_entry_valid, inst_queue_entry, issue_ready,
    input  inst_queue_ready, issue_valid, issue_entry
  );

  modport slave (
    input  inst_queue_entry_valid, inst_queue_entry, issue_ready,
    output inst_queue_ready, issue_valid, issue_entry
  );
endinterface

// File: rtl/instruction_queue.sv
// Circular FIFO of {pc, instruction} entries between fetch and decode/issue.
// Optional same-cycle bypass of an empty queue is enabled with INST_QUEUE_BYPASS_EN.
module instruction_queue #(
  parameter int ADDR_WIDTH     = 17,
  parameter int INST_WIDTH     = 32,
  parameter int QUEUE_SIZE_LOG = 3
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 rdy,
  input logic                 flush,
  instruction_queue_if.slave  q
);
  localparam int DEPTH       = 1 << QUEUE_SIZE_LOG;
  localparam int ENTRY_WIDTH = ADDR_WIDTH + INST_WIDTH;

  logic [ENTRY_WIDTH-1:0]    mem [DEPTH];
  logic [QUEUE_SIZE_LOG-1:0] head;
  logic [QUEUE_SIZE_LOG-1:0] tail;
  logic [QUEUE_SIZE_LOG:0]   count;

  logic full;
  logic empty;
  logic bypass;
  logic push_fire;
  logic pop_fire;
  logic do_push;
  logic do_pop;

  // count never exceeds DEPTH, so its MSB alone marks a full queue
  assign full  = count[QUEUE_SIZE_LOG];
  assign empty = (count == '0);

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = empty && q.inst_queue_entry_valid && rdy && !flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  assign q.inst_queue_ready = rdy && !rst && !full;
  assign q.issue_valid      = rdy && !rst && (!empty || bypass);
  assign q.issue_entry      = bypass ? q.inst_queue_entry : mem[head];

  assign push_fire = q.inst_queue_entry_valid && q.inst_queue_ready;
  assign pop_fire  = q.issue_valid && q.issue_ready;

  // A bypassed entry taken by the decoder never touches storage or pointers
  assign do_push = push_fire && !(bypass && q.issue_ready);
  assign do_pop  = pop_fire && !bypass;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + 1'b1;
        if (do_pop)  head <= head + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush && do_push) mem[tail] <= q.inst_queue_entry;
  end
endmodule
